nib_mem_responder: RTL and testbench
====================================

// Module: nib_mem_responder
// PURPOSE
//   Parametrised, synthesizable memory responder for the riscv_core NIB bus. It serves
//   instruction fetch over FETCH_LANES parallel lanes, lane k at pc_addr + k*LANE_STRIDE.
//   It serves one data port with byte enables, a programmable response latency and
//   deterministic stall injection. It replaces the zero-latency combinational memory model
//   in core and dual-core benches, and it doubles as an on-chip scratch RAM on FPGA.
// PARAMETERS
//   AW            32         byte address width
//   DW            32         data word width (multiple of 8)
//   DEPTH         4096       words per memory array (power of 2)
//   FETCH_LANES   2          parallel instruction words returned per fetch
//   LANE_STRIDE   32'h2000   byte offset between fetch lanes
//   PC_LAT        1          fetch latency in cycles (>=1, fully pipelined)
//   EX_LAT        1          data-port base latency in cycles (>=1)
//   STALL_EVERY   0          every Nth data request gets STALL_CYC extra cycles; 0 = off
//   STALL_CYC     3          extra wait cycles for an injected stall
//   IMEM_INIT     ""         $readmemh file for the instruction array ("" = zeros)
//   DMEM_INIT     ""         $readmemh file for the data array ("" = zeros)
// PORTS
//   clk           in   1                clock, rising edge
//   rst           in   1                asynchronous reset, active-high
//   pc_req_i      in   1                fetch request
//   pc_addr_i     in   AW               fetch byte address (word aligned)
//   pc_data_o     out  FETCH_LANES*DW   lane k in bits [k*DW +: DW]
//   pc_valid_o    out  1                pc_data_o valid
//   ex_req_i      in   1                data request, held until ex_gnt_o
//   ex_we_i       in   1                1 = write, 0 = read
//   ex_addr_i     in   AW               data byte address (word aligned)
//   ex_wdata_i    in   DW               write data
//   ex_be_i       in   DW/8             byte enables (writes only)
//   ex_gnt_o      out  1                1-cycle accept pulse that completes the request
//   ex_rdata_o    out  DW               read data, valid with ex_rvalid_o
//   ex_rvalid_o   out  1                read data valid (same cycle as ex_gnt_o)
//   hold_req_o    out  1                stall to core (drives nib_hold_req_i)
//   err_o         out  1                sticky out-of-range access flag
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, all counters 0, fetch pipeline flushed. Memory contents
//     are kept across reset.
//   Reset mid-operation: any in-flight request is dropped and no write commits.
//   Word index = addr[log2(DW/8) +: log2(DEPTH)].
//   Address out of range (any upper address bit set):
//     - read returns {DW/32{32'hDEADBEEF}}
//     - write is ignored
//     - err_o sets and stays set until rst
//   Fetch path:
//     - A pc_req_i in cycle t gives pc_valid_o=1 and data in cycle t+PC_LAT.
//     - A new request is accepted every cycle.
//     - A lane address that is out of range returns DEADBEEF for that lane only.
//   Data FSM: IDLE -> WAIT -> RESP -> IDLE.
//     - IDLE: ex_req_i=1 latches we/addr/wdata/be and loads wait_cnt = EX_LAT-1, plus
//       STALL_CYC when the stall condition holds. Next state is RESP if wait_cnt=0,
//       else WAIT.
//     - WAIT: wait_cnt decrements; go to RESP at 0.
//     - RESP:
//       - ex_gnt_o=1 for exactly one cycle.
//       - Read: ex_rvalid_o=1 and ex_rdata_o = memory at that cycle.
//       - Write: bytes with be=1 commit at the end of the cycle; be=0 bytes are unchanged.
//       - Always return to IDLE. A back-to-back request is taken in the next IDLE cycle.
//   Stall condition: STALL_EVERY != 0 and req_cnt % STALL_EVERY == STALL_EVERY-1.
//     req_cnt counts accepted data requests (wraps at 2^16).
//   hold_req_o=1 while the FSM is in WAIT, and in the IDLE cycle that accepts a request
//     when the next state is WAIT. It is 0 in RESP.
//   Simultaneous write and read to the same word: the read gets the pre-write value.
//     This applies to a data write against a fetch read in the same cycle.
//   Instruction and data arrays are separate. The data port never reaches the
//     instruction array.
//   Latency: a read takes EX_LAT cycles from acceptance to rvalid, plus STALL_CYC when
//     stalled. EX_LAT=1 with no stall gives the response in the cycle after acceptance.
// TESTING
//   1 Reset: rst=1 for 3 cycles with pc_req_i=1 and ex_req_i=1. All outputs must stay 0
//     and no write may commit. Release rst: first fetch valid PC_LAT cycles later.
//   2 Dual fetch: IMEM word0=32'h00000013, word 0x800=32'h02000057, pc_addr=0 ->
//     pc_data_o lane0=0x00000013, lane1=0x02000057, valid at t+PC_LAT. Streaming 4
//     consecutive addresses gives 4 consecutive valid cycles.
//   3 Byte write: write 0x11223344 to 0x40 with be=4'b1111, then 0xAABBCCDD with
//     be=4'b0101. Reading 0x40 returns 0x11BB33DD with rvalid=gnt=1 EX_LAT cycles
//     after acceptance.
//   4 Stall injection (EX_LAT=2, STALL_EVERY=3, STALL_CYC=3): 6 back-to-back reads.
//     Requests 3 and 6 take 5 cycles to gnt, all others 2. hold_req_o must be high
//     exactly during the wait cycles.
//   5 Out of range: read 0x0001_0000 (DEPTH=4096) returns 0xDEADBEEF and sets err_o.
//     A write to the same address leaves the data array unchanged. err_o clears only
//     on rst.
//   6 Collision: write 0x5 to word 8 in the same cycle as a read of word 8 -> the read
//     returns the old value; a read on the next request returns 0x5.

Source files
------------

// File: rtl/nib_mem_responder.sv
// Memory responder for the riscv_core NIB bus: pipelined multi-lane instruction fetch plus one
// data port with byte enables, programmable latency and periodic stall injection.
//
// state  | meaning
// S_IDLE | waiting for ex_req_i; accepts and latches a request
// S_WAIT | counting down extra latency cycles, hold_req_o high
// S_RESP | one-cycle grant; read data valid or write commits at cycle end
module nib_mem_responder #(
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter int              DEPTH       = 4096,
  parameter int              FETCH_LANES = 2,
  parameter logic [AW-1:0]   LANE_STRIDE = AW'(32'h2000),
  parameter int              PC_LAT      = 1,
  parameter int              EX_LAT      = 1,
  parameter int              STALL_EVERY = 0,
  parameter int              STALL_CYC   = 3,
  parameter string           IMEM_INIT   = "",
  parameter string           DMEM_INIT   = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pc_req_i,
  input  logic [AW-1:0]             pc_addr_i,
  output logic [FETCH_LANES*DW-1:0] pc_data_o,
  output logic                      pc_valid_o,
  input  logic                      ex_req_i,
  input  logic                      ex_we_i,
  input  logic [AW-1:0]             ex_addr_i,
  input  logic [DW-1:0]             ex_wdata_i,
  input  logic [DW/8-1:0]           ex_be_i,
  output logic                      ex_gnt_o,
  output logic [DW-1:0]             ex_rdata_o,
  output logic                      ex_rvalid_o,
  output logic                      hold_req_o,
  output logic                      err_o
);

  localparam int WB  = DW / 8;
  localparam int OFF = (WB > 1) ? $clog2(WB) : 0;
  localparam int IW  = $clog2(DEPTH);
  localparam int HI  = OFF + IW;
  localparam int SE  = (STALL_EVERY == 0) ? 1 : STALL_EVERY;
  localparam int CW  = $clog2(EX_LAT + STALL_CYC + 1);
  localparam logic [DW-1:0] DEAD = {(DW/32){32'hDEADBEEF}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DW-1:0] imem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];

  initial for (int i = 0; i < DEPTH; i++) imem[i] = '0;
  initial for (int i = 0; i < DEPTH; i++) dmem[i] = '0;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> HI) == '0;
  endfunction

  function automatic logic [IW-1:0] widx(input logic [AW-1:0] a);
    return a[OFF +: IW];
  endfunction

  // ---------------- fetch path ----------------
  logic [FETCH_LANES*DW-1:0] lane_rd;
  logic [FETCH_LANES-1:0]    lane_oor;
  logic [FETCH_LANES*DW-1:0] pc_pipe [PC_LAT];
  logic [PC_LAT-1:0]         pc_vld;

  for (genvar k = 0; k < FETCH_LANES; k++) begin : g_lane
    logic [AW-1:0] la;
    assign la                  = pc_addr_i + AW'(k) * LANE_STRIDE;
    assign lane_oor[k]         = !in_range(la);
    assign lane_rd[k*DW +: DW] = in_range(la) ? imem[widx(la)] : DEAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_vld <= '0;
      for (int i = 0; i < PC_LAT; i++) pc_pipe[i] <= '0;
    end else begin
      pc_vld[0]  <= pc_req_i;
      pc_pipe[0] <= pc_req_i ? lane_rd : '0;
      for (int i = 1; i < PC_LAT; i++) begin
        pc_vld[i]  <= pc_vld[i-1];
        pc_pipe[i] <= pc_pipe[i-1];
      end
    end
  end

  assign pc_valid_o = pc_vld[PC_LAT-1];
  assign pc_data_o  = pc_pipe[PC_LAT-1];

  // ---------------- data port ----------------
  state_t          state;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [WB-1:0]   be_q;
  logic [CW-1:0]   wait_cnt;
  logic [15:0]     req_cnt;
  logic            stall_now;
  logic [CW-1:0]   load_cnt;

  assign stall_now = (STALL_EVERY != 0) && ((int'(req_cnt) % SE) == (SE - 1));
  assign load_cnt  = CW'(EX_LAT - 1) + (stall_now ? CW'(STALL_CYC) : CW'(0));
  assign hold_req_o = !rst && ((state == S_WAIT) ||
                               (state == S_IDLE && ex_req_i && load_cnt != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      wait_cnt    <= '0;
      req_cnt     <= '0;
      ex_gnt_o    <= 1'b0;
      ex_rvalid_o <= 1'b0;
      ex_rdata_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      ex_gnt_o    <= 1'b0;
      ex_rvalid_o <= 1'b0;
      ex_rdata_o  <= '0;
      case (state)
        S_IDLE: if (ex_req_i) begin
          we_q     <= ex_we_i;
          addr_q   <= ex_addr_i;
          wdata_q  <= ex_wdata_i;
          be_q     <= ex_be_i;
          wait_cnt <= load_cnt;
          req_cnt  <= req_cnt + 16'd1;
          if (load_cnt == '0) begin
            state       <= S_RESP;
            ex_gnt_o    <= 1'b1;
            ex_rvalid_o <= !ex_we_i;
            ex_rdata_o  <= ex_we_i ? '0 : (in_range(ex_addr_i) ? dmem[widx(ex_addr_i)] : DEAD);
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) begin
            state       <= S_RESP;
            ex_gnt_o    <= 1'b1;
            ex_rvalid_o <= !we_q;
            ex_rdata_o  <= we_q ? '0 : (in_range(addr_q) ? dmem[widx(addr_q)] : DEAD);
          end
        end
        default: begin
          state <= S_IDLE;
          if (!in_range(addr_q)) err_o <= 1'b1;
        end
      endcase
      if (pc_req_i && |lane_oor) err_o <= 1'b1;
    end
  end

  // Write commits at the end of the grant cycle; a reset clears state first so it cannot commit.
  always_ff @(posedge clk) begin
    if (state == S_RESP && we_q && in_range(addr_q)) begin
      for (int b = 0; b < WB; b++) begin
        if (be_q[b]) dmem[widx(addr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_nib_mem_responder.sv
// Randomized scoreboard bench for nib_mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_nib_mem_responder;
  localparam int DEPTH = 4096;
  localparam int PC_LAT = 2;
  localparam int EX_LAT = 2;
  localparam int STALL_EVERY = 3;
  localparam int STALL_CYC = 3;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_req_i = 1'b0;
  logic [31:0] pc_addr_i = '0;
  logic [63:0] pc_data_o;
  logic        pc_valid_o;
  logic        ex_req_i = 1'b0;
  logic        ex_we_i = 1'b0;
  logic [31:0] ex_addr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic [3:0]  ex_be_i = '0;
  logic        ex_gnt_o;
  logic [31:0] ex_rdata_o;
  logic        ex_rvalid_o;
  logic        hold_req_o;
  logic        err_o;

  nib_mem_responder #(
    .DEPTH(DEPTH), .PC_LAT(PC_LAT), .EX_LAT(EX_LAT),
    .STALL_EVERY(STALL_EVERY), .STALL_CYC(STALL_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .pc_req_i(pc_req_i), .pc_addr_i(pc_addr_i), .pc_data_o(pc_data_o), .pc_valid_o(pc_valid_o),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
    .ex_be_i(ex_be_i), .ex_gnt_o(ex_gnt_o), .ex_rdata_o(ex_rdata_o), .ex_rvalid_o(ex_rvalid_o),
    .hold_req_o(hold_req_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; bit we; logic [31:0] rdata; } ex_exp_t;
  typedef struct { int cyc; logic [63:0] data; } pc_exp_t;
  ex_exp_t exq[$];
  pc_exp_t pcq[$];
  int hold_from = -1;
  int hold_to = -1;

  // Reference model state
  logic [31:0] ref_imem [DEPTH];
  logic [31:0] ref_dmem [DEPTH];
  int          n_req = 0;
  bit          err_exp = 0;

  function automatic int req_latency(input int n);
    return EX_LAT + (((n % STALL_EVERY) == STALL_EVERY - 1) ? STALL_CYC : 0);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    ex_exp_t e;
    pc_exp_t p;
    if (!rst) begin
      check("hold_req", {63'd0, hold_req_o}, {63'd0, (cyc >= hold_from && cyc < hold_to)});
      if (ex_gnt_o) begin
        if (exq.size() == 0) check("ex_gnt_unexpected", {63'd0, ex_gnt_o}, 64'd0);
        else begin
          e = exq.pop_front();
          check("ex_gnt_cycle", 64'(cyc), 64'(e.cyc));
          check("ex_rvalid", {63'd0, ex_rvalid_o}, {63'd0, !e.we});
          if (!e.we) check("ex_rdata", {32'd0, ex_rdata_o}, {32'd0, e.rdata});
        end
      end else begin
        check("ex_rvalid_idle", {63'd0, ex_rvalid_o}, 64'd0);
        if (exq.size() > 0 && exq[0].cyc <= cyc) begin
          check("ex_gnt_missing", {63'd0, ex_gnt_o}, 64'd1);
          void'(exq.pop_front());
        end
      end
      if (pc_valid_o) begin
        if (pcq.size() == 0) check("pc_valid_unexpected", {63'd0, pc_valid_o}, 64'd0);
        else begin
          p = pcq.pop_front();
          check("pc_valid_cycle", 64'(cyc), 64'(p.cyc));
          check("pc_data", pc_data_o, p.data);
        end
      end else if (pcq.size() > 0 && pcq[0].cyc <= cyc) begin
        check("pc_valid_missing", {63'd0, pc_valid_o}, 64'd1);
        void'(pcq.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] addr);
    pc_exp_t     p;
    logic [31:0] la;
    p.data = '0;
    for (int k = 0; k < 2; k++) begin
      la = addr + 32'(k) * 32'h2000;
      if (la >= 32'(DEPTH * 4)) begin
        p.data[k*32 +: 32] = DEAD;
        err_exp = 1;
      end else begin
        p.data[k*32 +: 32] = ref_imem[int'(la >> 2)];
      end
    end
    p.cyc = cyc + PC_LAT;
    pcq.push_back(p);
    pc_req_i  = 1'b1;
    pc_addr_i = addr;
    @(posedge clk);
    #1;
    pc_req_i = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    ex_exp_t e;
    int      lat;
    int      idx;
    bit      inr;
    bit      got;
    lat = req_latency(n_req);
    n_req = (n_req + 1) % 65536;
    inr = addr < 32'(DEPTH * 4);
    idx = int'(addr >> 2) % DEPTH;
    e.we = we;
    e.rdata = inr ? ref_dmem[idx] : DEAD;
    if (!inr) err_exp = 1;
    if (we && inr)
      for (int b = 0; b < 4; b++) if (be[b]) ref_dmem[idx][8*b +: 8] = wdata[8*b +: 8];
    e.cyc = cyc + lat;
    exq.push_back(e);
    hold_from = cyc;
    hold_to = (lat > 1) ? cyc + lat : cyc;
    ex_req_i = 1'b1; ex_we_i = we; ex_addr_i = addr; ex_wdata_i = wdata; ex_be_i = be;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ex_gnt_o;
    end
    if (!got) check("ex_req_timeout", {63'd0, ex_gnt_o}, 64'd1);
    @(posedge clk);
    #1;
    ex_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int lat;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      ref_imem[i] = $urandom;
      ref_dmem[i] = '0;
    end
    ref_imem[0] = 32'h00000013;
    ref_imem[12'h800] = 32'h02000057;
    for (int i = 0; i < DEPTH; i++) dut.imem[i] = ref_imem[i];

    // Reset with both ports requesting: nothing may come out, nothing may commit.
    rst = 1'b1;
    pc_req_i = 1'b1; pc_addr_i = 32'h0;
    ex_req_i = 1'b1; ex_we_i = 1'b1; ex_addr_i = 32'h40; ex_wdata_i = 32'hFFFFFFFF; ex_be_i = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("rst_pc_valid", {63'd0, pc_valid_o}, 64'd0);
      check("rst_pc_data", pc_data_o, 64'd0);
      check("rst_gnt", {63'd0, ex_gnt_o}, 64'd0);
      check("rst_rvalid", {63'd0, ex_rvalid_o}, 64'd0);
      check("rst_rdata", {32'd0, ex_rdata_o}, 64'd0);
      check("rst_hold", {63'd0, hold_req_o}, 64'd0);
      check("rst_err", {63'd0, err_o}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; pc_req_i = 1'b0; ex_req_i = 1'b0;

    // Dual-lane fetch, then a 4-deep stream
    fetch(32'h0);
    idle(3);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4));
    idle(4);

    // Six back-to-back reads; the first confirms the reset-time write never landed
    do_req(0, 32'h40, '0, '0);
    for (int i = 0; i < 5; i++) do_req(0, 32'($urandom_range(0, 63) * 4), '0, '0);
    idle(3);

    // Byte-enable merge
    do_req(1, 32'h40, 32'h11223344, 4'b1111);
    do_req(1, 32'h40, 32'hAABBCCDD, 4'b0101);
    do_req(0, 32'h40, '0, '0);
    idle(2);

    // Same word read / write / read
    do_req(0, 32'h20, '0, '0);
    do_req(1, 32'h20, 32'h5, 4'hF);
    do_req(0, 32'h20, '0, '0);
    idle(2);

    // Out of range: DEADBEEF, write dropped (no aliasing onto word 0), sticky error
    check("err_before_oor", {63'd0, err_o}, 64'd0);
    do_req(0, 32'h0001_0000, '0, '0);
    do_req(1, 32'h0001_0000, 32'h12345678, 4'hF);
    do_req(0, 32'h0, '0, '0);
    idle(2);
    check("err_after_oor", {63'd0, err_o}, {63'd0, err_exp});
    fetch(32'h3000);
    idle(4);

    // Concurrent random traffic on both ports
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [31:0] a;
          a = ($urandom_range(0, 9) == 0) ? 32'h0001_0000 + 32'($urandom_range(0, 15) * 4)
                                          : 32'($urandom_range(0, 63) * 4);
          do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          fetch(32'($urandom_range(0, 12'h7FF) * 4));
          idle($urandom_range(0, 1));
        end
      end
    join
    idle(6);
    check("err_sticky", {63'd0, err_o}, 64'd1);

    // Reset while a write sits in WAIT: it must be dropped
    lat = req_latency(n_req);
    hold_from = cyc;
    hold_to = cyc + lat;
    ex_req_i = 1'b1; ex_we_i = 1'b1; ex_addr_i = 32'h80; ex_wdata_i = 32'hCAFEF00D; ex_be_i = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b1; ex_req_i = 1'b0;
    exq.delete(); pcq.delete();
    hold_from = -1; hold_to = -1;
    @(negedge clk);
    check("midrst_gnt", {63'd0, ex_gnt_o}, 64'd0);
    check("midrst_err", {63'd0, err_o}, 64'd0);
    idle(2);
    rst = 1'b0;
    n_req = 0;
    err_exp = 0;
    do_req(0, 32'h80, '0, '0);
    idle(3);
    check("err_after_rst", {63'd0, err_o}, 64'd0);
    check("ex_queue_drained", 64'(exq.size()), 64'd0);
    check("pc_queue_drained", 64'(pcq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
